// File: rtl/bpu_pc_gen.sv
// Pre-IF next-PC generator feeding the BTB lookup and the IF stage.
// Tracks one in-flight PC (s0) and keeps its prediction while IF stalls.
module bpu_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_en,
    input  logic [31:0] flush_pc,
    output logic [31:0] fetch_pc,
    output logic        fetch_en,
    input  logic [31:0] btb_ret_pc,
    input  logic        btb_taken,
    input  logic        btb_ret_en,
    input  logic [4:0]  btb_ret_index,
    input  logic        fs_allowin,
    output logic        fs_valid,
    output logic [31:0] fs_pc,
    output logic        fs_pred_en,
    output logic        fs_pred_taken,
    output logic [31:0] fs_pred_target,
    output logic [4:0]  fs_pred_index
);

    typedef struct packed {
        logic        en;
        logic        taken;
        logic [31:0] target;
        logic [4:0]  index;
    } pred_t;

    logic        s0_valid;
    logic        s0_fresh;
    logic [31:0] s0_pc;
    pred_t       hold;
    pred_t       btb;
    pred_t       src;
    logic        pred_taken;
    logic        s0_live;
    logic        sel_flush;
    logic        sel_boot;
    logic        sel_pred;
    logic [31:0] seq_pc;
    logic [31:0] npc;

    assign btb = {btb_ret_en, btb_taken, btb_ret_pc, btb_ret_index};

    // BTB outputs only belong to s0 in the cycle right after its lookup
    assign src        = s0_fresh ? btb : hold;
    assign pred_taken = src.en & src.taken;
    assign s0_live    = s0_valid & ~reset;
    assign seq_pc     = s0_pc + 32'd4;

    assign sel_flush = flush_en;
    assign sel_boot  = ~flush_en & ~s0_valid;
    assign sel_pred  = ~flush_en & s0_valid & pred_taken;

    // Next-PC select: flush, boot, predicted target, sequential
    always_comb begin
        npc = seq_pc;
        unique case (1'b1)
            sel_flush: npc = flush_pc;
            sel_boot:  npc = RESET_PC;
            sel_pred:  npc = src.target;
            default:   npc = seq_pc;
        endcase
    end

    assign fetch_en = ~reset & (flush_en | ~s0_valid | fs_allowin);
    assign fetch_pc = npc;

    assign fs_valid       = s0_live & ~flush_en;
    assign fs_pc          = s0_pc;
    assign fs_pred_en     = s0_live & src.en;
    assign fs_pred_taken  = s0_live & pred_taken;
    assign fs_pred_target = s0_live ? src.target : 32'd0;
    assign fs_pred_index  = s0_live ? src.index : 5'd0;

    // s0 advances on every lookup; freshness expires on the first stall cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid <= 1'b0;
            s0_fresh <= 1'b0;
            s0_pc    <= 32'd0;
        end else if (fetch_en) begin
            s0_valid <= 1'b1;
            s0_fresh <= 1'b1;
            s0_pc    <= npc;
        end else if (s0_fresh) begin
            s0_fresh <= 1'b0;
        end
    end

    // Capture the BTB answer before it goes stale so a stall keeps it
    always_ff @(posedge clk) begin
        if (reset) begin
            hold <= '0;
        end else if (~fetch_en && s0_fresh) begin
            hold <= btb;
        end
    end

endmodule
